// File: rtl/axis_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : axis_sequence_checker
// Purpose  : AXI4-Stream sink that checks one N-beat packet against the
//            incrementing-byte pattern and reports pass/fail and counts.
//            Define AXIS_CHK_BACKPRESSURE_EN to throttle TREADY from an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module axis_sequence_checker #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [7:0]  START_BYTE = 8'h80,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  i_enable,
   input  logic [31:0]           i_n_value,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [31:0]           o_beat_count,
   output logic [15:0]           o_error_count,
   output logic [31:0]           o_first_err_beat
);

   localparam int         c_lanes     = DATA_WIDTH / 8;
   localparam logic [7:0] c_lane_step = 8'(c_lanes);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;

   logic [31:0]  r_n_value;
   logic [31:0]  r_beat_count;
   logic [31:0]  r_first_err_beat;
   logic [15:0]  r_error_count;
   logic [7:0]   r_exp_byte;
   logic         r_pass;

   logic              w_arm;
   logic              w_throttle_ok;
   logic              w_tready;
   logic              w_accept;
   logic [c_lanes-1:0] w_lane_ok;
   logic [31:0]       w_beat_k;
   logic              w_k_is_n;
   logic              w_beat_bad;
   logic              w_pkt_end;
   logic [15:0]       w_err_next;

   // Lane i of the current beat must carry exp + i, wrapping mod 256.
   generate
      for (genvar gi = 0; gi < c_lanes; gi++) begin : g_lane
         assign w_lane_ok[gi] = (s_axis_tdata[8*gi +: 8] == (r_exp_byte + 8'(gi)));
      end
   endgenerate

`ifdef AXIS_CHK_BACKPRESSURE_EN
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_arm) begin
         r_lfsr <= LFSR_SEED;
      end else if (r_state == S_RECV) begin
         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   assign w_throttle_ok = r_lfsr[0] | r_lfsr[1];
`else
   assign w_throttle_ok = 1'b1;
`endif

   assign w_arm      = (r_state == S_IDLE) && i_enable && (i_n_value != 32'd0);
   assign w_tready   = (r_state == S_RECV) && w_throttle_ok;
   assign w_accept   = w_tready && s_axis_tvalid;

   assign w_beat_k   = r_beat_count + 32'd1;
   assign w_k_is_n   = (w_beat_k == r_n_value);
   assign w_beat_bad = !(&w_lane_ok) || (s_axis_tlast != w_k_is_n);
   assign w_pkt_end  = s_axis_tlast || w_k_is_n;
   assign w_err_next = (w_beat_bad && (r_error_count != 16'hFFFF)) ?
                       (r_error_count + 16'd1) : r_error_count;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_arm) begin
               w_state_nxt = S_RECV;
            end
         end
         S_RECV: begin
            if (w_accept && w_pkt_end) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_n_value        <= 32'd0;
         r_beat_count     <= 32'd0;
         r_first_err_beat <= 32'd0;
         r_error_count    <= 16'd0;
         r_exp_byte       <= START_BYTE;
         r_pass           <= 1'b0;
      end else if (w_arm) begin
         r_n_value        <= i_n_value;
         r_beat_count     <= 32'd0;
         r_first_err_beat <= 32'd0;
         r_error_count    <= 16'd0;
         r_exp_byte       <= START_BYTE;
         r_pass           <= 1'b0;
      end else if (w_accept) begin
         r_beat_count  <= w_beat_k;
         r_exp_byte    <= r_exp_byte + c_lane_step;
         r_error_count <= w_err_next;
         if (w_beat_bad && (r_first_err_beat == 32'd0)) begin
            r_first_err_beat <= w_beat_k;
         end
         // Result is settled on the final beat so it is already valid during DONE.
         if (w_pkt_end) begin
            r_pass <= (w_err_next == 16'd0);
         end
      end
   end

   assign s_axis_tready    = w_tready;
   assign o_busy           = (r_state == S_RECV);
   assign o_done           = (r_state == S_DONE);
   assign o_pass           = r_pass;
   assign o_beat_count     = r_beat_count;
   assign o_error_count    = r_error_count;
   assign o_first_err_beat = r_first_err_beat;

endmodule
`default_nettype wire

// File: doc/axis_sequence_checker.md
Name: axis_sequence_checker

Overview:
- AXI4-Stream sink placed directly downstream of the number generator in the aximm_test2 bench datapath.
- Accepts one packet of N beats and checks each byte lane against the generator's incrementing-byte pattern.
- Checks that TLAST falls exactly on beat N, then reports pass/fail, the beat count, the error count and the index of the first failing beat.
- Drives TREADY; optional LFSR-based throttling exercises upstream backpressure.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8; lanes L = DATA_WIDTH/8
START_BYTE, 8'h80, expected value of byte lane 0 on beat 1
LFSR_SEED, 16'hACE1, backpressure LFSR reset/start value (nonzero)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
i_enable  in  1  arms the checker for one packet
i_n_value  in  32  expected beat count N
s_axis_tvalid  in  1  upstream data valid
s_axis_tdata  in  DATA_WIDTH  upstream data
s_axis_tlast  in  1  upstream last beat
s_axis_tready  out  1  checker ready
o_busy  out  1  high while in RECV
o_done  out  1  one-cycle pulse when a packet check completes
o_pass  out  1  result of the last completed packet
o_beat_count  out  32  beats accepted in the current/last packet
o_error_count  out  16  failing beats; saturates at 16'hFFFF
o_first_err_beat  out  32  1-based index of the first failing beat; 0 if none

Behaviour:
- Reset, asynchronous: state=IDLE; s_axis_tready=0; o_busy=0; o_done=0; o_pass=0; all counts=0; expected byte=START_BYTE; LFSR=LFSR_SEED.
- Assertion of aresetn mid-packet aborts the check with no o_done pulse. The next packet must be re-armed.
- IDLE:
  - s_axis_tready=0.
  - On i_enable=1 and i_n_value>0: latch N, expected byte=START_BYTE, clear beat count, error count, first-error beat and o_pass, LFSR=LFSR_SEED, go to RECV.
  - i_n_value=0: request ignored, stay in IDLE.
- RECV:
  - o_busy=1; s_axis_tready=1, or throttled when the optional feature is compiled in.
  - A beat is accepted when s_axis_tvalid and s_axis_tready are both high. Per accepted beat k (1-based):
    - Lane i must equal (exp + i) mod 256.
    - TLAST must equal (k == N).
    - Any lane or TLAST mismatch counts as one failing beat: error count +1 (saturating). If the first-error beat is still 0, record k.
    - exp <= (exp + L) mod 256; the byte wrap is silent and legal. Beat count +1.
  - Packet end is the accepted beat with tlast=1 or k==N, whichever comes first; then go to DONE.
  - Early TLAST ends the packet at beat k<N with that beat failing.
  - Missing TLAST at k==N ends the packet with that beat failing. Any later beats stay unaccepted because tready=0 in IDLE.
  - i_enable is ignored while in RECV.
- DONE (one cycle):
  - s_axis_tready=0; o_done=1; o_pass=(error count==0).
  - Return to IDLE.
  - o_pass, o_beat_count, o_error_count and o_first_err_beat hold until the next arm.
- Latency: o_done is asserted 1 cycle after the final accepted beat.
- The checker never requires tvalid before tready; a tvalid drop mid-packet stalls without error.

Optional Feature:
Macro AXIS_CHK_BACKPRESSURE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle in RECV.
  - s_axis_tready = lfsr[0] | lfsr[1] in RECV, about 75% duty.
  - Throttling is deterministic from LFSR_SEED.
- Undefined: LFSR logic absent; s_axis_tready=1 throughout RECV.

Test Plan:
- DATA_WIDTH=32, N=3, correct stream 32'h83828180, 32'h87868584, 32'h8B8A8988 with tlast on beat 3 -> o_done 1 cycle after beat 3; o_pass=1; beat_count=3; error_count=0; first_err_beat=0.
- N=40, correct stream -> beat 33 tdata=32'h03020100, beat 40 tdata=32'h1F1E1D1C; pass=1. Verifies mod-256 wrap.
- N=4, tlast asserted on beat 2 -> done after beat 2; beat_count=2; error_count=1; first_err_beat=2; pass=0.
- N=2, byte lane 1 of beat 2 = 8'h00 (expect 8'h85), tlast correct -> error_count=1; first_err_beat=2; pass=0. Then N=2 with tlast never asserted -> ends at beat 2; error_count=1; pass=0.
- With AXIS_CHK_BACKPRESSURE_EN defined, N=16, source holds tvalid=1 -> every beat accepted exactly once; tready pattern matches the LFSR model from 16'hACE1; pass=1.
- Deassert aresetn after beat 2 of N=8 -> all outputs return to reset values next cycle with no o_done; re-arm with N=1 and beat 32'h83828180, tlast=1 -> pass=1.
